// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer
//   Advances an LED pattern (shift, bounce, fill or blink) by one step for each
//   accepted step tick. leds and cycle_done are registered outputs; cycle_done
//   pulses for one clock after the step that completes a full pattern period.
module led_pattern_sequencer #(
  parameter int LED_COUNT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 step,
  input  logic                 enable,
  input  logic [1:0]           mode,
  input  logic                 mode_we,
  output logic [LED_COUNT-1:0] leds,
  output logic                 cycle_done
);

  localparam int POS_W = $clog2(LED_COUNT);
  localparam int CNT_W = $clog2(LED_COUNT + 1);

  localparam logic [POS_W-1:0]     POS_MAX  = POS_W'(LED_COUNT - 1);
  localparam logic [CNT_W-1:0]     CNT_MAX  = CNT_W'(LED_COUNT);
  localparam logic [LED_COUNT-1:0] LED_ONE  = LED_COUNT'(1);
  localparam logic [LED_COUNT-1:0] LED_ALL  = {LED_COUNT{1'b1}};
  localparam logic [LED_COUNT-1:0] LED_NONE = '0;

  typedef enum logic [1:0] {
    MODE_SHIFT  = 2'd0,
    MODE_BOUNCE = 2'd1,
    MODE_FILL   = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  mode_e                mode_q, mode_d;
  mode_e                mode_in;
  dir_e                 dir_q, dir_d;
  logic [POS_W-1:0]     pos_q, pos_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 phase_q, phase_d;
  logic [LED_COUNT-1:0] leds_q, leds_d;
  logic                 cycle_done_q, cycle_done_d;

  assign mode_in = mode_e'(mode);

  // Next-state and next-output logic: mode load beats an accepted step, else hold.
  always_comb begin
    // NOTE: every variable gets a default before any branch so that no path
    // leaves one unassigned, which would otherwise infer a latch.
    mode_d       = mode_q;
    dir_d        = dir_q;
    pos_d        = pos_q;
    cnt_d        = cnt_q;
    phase_d      = phase_q;
    leds_d       = leds_q;
    cycle_done_d = 1'b0;

    if (mode_we) begin
      // Restart the newly selected pattern; a coincident step is dropped.
      mode_d  = mode_in;
      dir_d   = DIR_UP;
      pos_d   = '0;
      cnt_d   = '0;
      phase_d = (mode_in == MODE_BLINK);
      case (mode_in)
        MODE_SHIFT:  leds_d = LED_ONE;
        MODE_BOUNCE: leds_d = LED_ONE;
        MODE_FILL:   leds_d = LED_NONE;
        MODE_BLINK:  leds_d = LED_ALL;
        default:     leds_d = LED_ONE;
      endcase
    end else if (step && enable) begin
      case (mode_q)
        MODE_SHIFT: begin
          if (pos_q == POS_MAX) begin
            pos_d        = '0;
            cycle_done_d = 1'b1;
          end else begin
            pos_d = pos_q + 1'b1;
          end
          leds_d = LED_ONE << pos_d;
        end

        MODE_BOUNCE: begin
          // Direction flips as an endpoint is reached, so each endpoint is
          // lit for exactly one step before the walk turns around.
          if (dir_q == DIR_UP) begin
            pos_d = pos_q + 1'b1;
            if (pos_d == POS_MAX) begin
              dir_d = DIR_DOWN;
            end
          end else begin
            pos_d = pos_q - 1'b1;
            if (pos_d == '0) begin
              dir_d        = DIR_UP;
              cycle_done_d = 1'b1;
            end
          end
          leds_d = LED_ONE << pos_d;
        end

        MODE_FILL: begin
          if (cnt_q == CNT_MAX) begin
            cnt_d        = '0;
            cycle_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
          // Equivalent to ((1 << cnt) - 1) taken LED_COUNT+1 bits wide: a shift
          // by LED_COUNT empties the mask, so the inverse lights every LED.
          leds_d = ~(LED_ALL << cnt_d);
        end

        MODE_BLINK: begin
          phase_d      = ~phase_q;
          cycle_done_d = phase_q;
          leds_d       = phase_d ? LED_ALL : LED_NONE;
        end

        default: begin
          leds_d = leds_q;
        end
      endcase
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q       <= MODE_SHIFT;
      dir_q        <= DIR_UP;
      pos_q        <= '0;
      cnt_q        <= '0;
      phase_q      <= 1'b0;
      leds_q       <= LED_ONE;
      cycle_done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values computed by the combinational block.
      mode_q       <= mode_d;
      dir_q        <= dir_d;
      pos_q        <= pos_d;
      cnt_q        <= cnt_d;
      phase_q      <= phase_d;
      leds_q       <= leds_d;
      cycle_done_q <= cycle_done_d;
    end
  end

  assign leds       = leds_q;
  assign cycle_done = cycle_done_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb_led_pattern_sequencer
//   Directed bench for led_pattern_sequencer with LED_COUNT=8. Inputs change on
//   the falling edge; outputs are compared on the following falling edge.
module tb_led_pattern_sequencer;

  localparam int LED_COUNT = 8;

  logic                 clk;
  logic                 reset;
  logic                 step;
  logic                 enable;
  logic [1:0]           mode;
  logic                 mode_we;
  logic [LED_COUNT-1:0] leds;
  logic                 cycle_done;

  int n_checks = 0;
  int n_passed = 0;

  led_pattern_sequencer #(.LED_COUNT(LED_COUNT)) dut (
    .clk        (clk),
    .reset      (reset),
    .step       (step),
    .enable     (enable),
    .mode       (mode),
    .mode_we    (mode_we),
    .leds       (leds),
    .cycle_done (cycle_done)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_passed++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One single-clock step pulse, then compare the result.
  task automatic do_step(input string tag, input logic [7:0] exp_leds, input logic exp_done);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    check({tag, " leds"}, 32'(leds), 32'(exp_leds));
    check({tag, " done"}, 32'(cycle_done), 32'(exp_done));
  endtask

  // Load a mode (optionally with a coincident step) and compare the restart value.
  task automatic load_mode(input string tag, input logic [1:0] m, input logic with_step,
                           input logic [7:0] exp_leds);
    mode    = m;
    mode_we = 1'b1;
    step    = with_step;
    @(negedge clk);
    mode_we = 1'b0;
    step    = 1'b0;
    check({tag, " leds"}, 32'(leds), 32'(exp_leds));
    check({tag, " done"}, 32'(cycle_done), 32'(1'b0));
  endtask

  initial begin
    int p;
    int c;
    logic [7:0] e;

    reset   = 1'b0;
    step    = 1'b0;
    enable  = 1'b1;
    mode    = 2'd0;
    mode_we = 1'b0;
    #12;
    check("reset leds", 32'(leds), 32'h01);
    check("reset done", 32'(cycle_done), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post reset leds", 32'(leds), 32'h01);

    // SHIFT: 02,04,...,80,01 with one cycle_done on the wrap.
    for (int i = 0; i < 8; i++) begin
      e = 8'(1 << ((i + 1) % 8));
      do_step($sformatf("shift %0d", i), e, (i == 7));
    end
    @(negedge clk);
    check("shift idle done", 32'(cycle_done), 32'h0);

    // BOUNCE: 02..80 then 40..01, cycle_done on the 14th step only.
    load_mode("bounce load", 2'd1, 1'b0, 8'h01);
    for (int i = 0; i < 14; i++) begin
      p = (i < 7) ? (i + 1) : (13 - i);
      e = 8'(1 << p);
      do_step($sformatf("bounce %0d", i), e, (i == 13));
    end

    // FILL: 01,03,...,FF,00 with cycle_done on FF->00.
    load_mode("fill load", 2'd2, 1'b0, 8'h00);
    for (int i = 0; i < 9; i++) begin
      c = (i + 1) % 9;
      e = 8'(((1 << c) - 1) & 8'hFF);
      do_step($sformatf("fill %0d", i), e, (i == 8));
    end

    // BLINK with step held for four clocks: 00,FF,00,FF; done on clk 1 and 3.
    load_mode("blink load", 2'd3, 1'b0, 8'hFF);
    step = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      e = (i % 2 == 0) ? 8'h00 : 8'hFF;
      check($sformatf("blink held %0d leds", i), 32'(leds), 32'(e));
      check($sformatf("blink held %0d done", i), 32'(cycle_done), 32'(i % 2 == 0));
    end
    step = 1'b0;
    @(negedge clk);
    check("blink release leds", 32'(leds), 32'hFF);
    check("blink release done", 32'(cycle_done), 32'h0);

    // FILL to 0x07, then mode_we (SHIFT) with a coincident step: restart wins.
    load_mode("fill2 load", 2'd2, 1'b0, 8'h00);
    do_step("fill2 a", 8'h01, 1'b0);
    do_step("fill2 b", 8'h03, 1'b0);
    do_step("fill2 c", 8'h07, 1'b0);
    load_mode("we beats step", 2'd0, 1'b1, 8'h01);

    // enable=0: steps are ignored and cycle_done stays low.
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      do_step($sformatf("frozen %0d", i), 8'h01, 1'b0);
    end
    enable = 1'b1;
    do_step("unfrozen", 8'h02, 1'b0);

    // Drive SHIFT to 0x20, then assert reset between clock edges.
    do_step("to20 a", 8'h04, 1'b0);
    do_step("to20 b", 8'h08, 1'b0);
    do_step("to20 c", 8'h10, 1'b0);
    do_step("to20 d", 8'h20, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check("async reset leds", 32'(leds), 32'h01);
    check("async reset done", 32'(cycle_done), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    do_step("after reset", 8'h02, 1'b0);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
